branch_unit: RTL

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// Branch/call/return resolver with a return-address stack and a one-cycle decode flush.
// Redirect is combinational in the issuing cycle; there is no backpressure, and i_Op is ignored in the flush cycle.
module branch_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [2:0] i_Op,
  input  logic [7:0] i_Target,
  input  logic [7:0] i_PC,
  input  logic       i_Zero,
  input  logic       i_Carry,
  input  logic       i_Flag_We,
  output logic [7:0] direc_sal,
  output logic       hab_sal,
  output logic       o_Flush,
  output logic [3:0] o_Depth,
  output logic       o_Stack_Ovf,
  output logic       o_Stack_Unf
);

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_JC   = 3'b110;
  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state, state_nxt;
  logic [3:0] sp;
  logic       z_q, c_q;
  logic       ovf_q, unf_q;
  logic [7:0] stack_mem [0:7];

  logic       taken, push, pop, ovf_set, unf_set;
  logic [7:0] tgt;
  logic [7:0] ret_addr;
  logic [2:0] tos_idx;

  assign ret_addr = i_PC + 8'd1;
  assign tos_idx  = sp[2:0] - 3'd1;

  always_comb begin
    taken     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    tgt       = 8'h00;
    state_nxt = state;
    if (state == FLUSH) begin
      state_nxt = RUN;
    end else begin
      case (i_Op)
        OP_JMP: begin
          taken = 1'b1;
          tgt   = i_Target;
        end
        OP_JZ: begin
          taken = z_q;
          tgt   = i_Target;
        end
        OP_JNZ: begin
          taken = ~z_q;
          tgt   = i_Target;
        end
        OP_JC: begin
          taken = c_q;
          tgt   = i_Target;
        end
        OP_CALL: begin
          // A full stack still jumps; only the return address is lost.
          taken = 1'b1;
          tgt   = i_Target;
          if (sp == DEPTH_MAX) ovf_set = 1'b1;
          else                 push    = 1'b1;
        end
        OP_RET: begin
          if (sp != 4'd0) begin
            taken = 1'b1;
            pop   = 1'b1;
            tgt   = stack_mem[tos_idx];
          end else begin
            unf_set = 1'b1;
          end
        end
        default: ;
      endcase
      if (taken) state_nxt = FLUSH;
    end
  end

  assign hab_sal     = taken & ~i_Rst;
  assign direc_sal   = hab_sal ? tgt : 8'h00;
  assign o_Flush     = (state == FLUSH);
  assign o_Depth     = sp;
  assign o_Stack_Ovf = ovf_q;
  assign o_Stack_Unf = unf_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= RUN;
      sp    <= 4'd0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (i_Flag_We) begin
        z_q <= i_Zero;
        c_q <= i_Carry;
      end
      if (push)    sp    <= sp + 4'd1;
      if (pop)     sp    <= sp - 4'd1;
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  // Stack contents need no reset; only the pointer defines validity.
  always_ff @(posedge i_Clk) begin
    if (push && !i_Rst) stack_mem[sp[2:0]] <= ret_addr;
  end

endmodule
